mux_sequencer: RTL and testbench

MUX_SEQUENCER -- requirements
Module: mux_sequencer

---
 rtl/mux_sequencer.sv | 148 ++++++++++++++
 tb/tb_mux_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sequencer.sv
// Break-before-make analog mux sequencer: each switchSignal high period advances
// to the next enabled channel, with dead time between disabling and re-enabling.
module mux_sequencer #(
    parameter int ADDR_W      = 3,
    parameter int BANK_W      = 2,
    parameter int NUM_CH      = 18,
    parameter int DEAD_CYCLES = 2,
    localparam int CH_W       = ($clog2(NUM_CH) > 5) ? $clog2(NUM_CH) : 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              switchSignal,
    input  logic              restart,
    input  logic [NUM_CH-1:0] chMask,
    output logic [ADDR_W-1:0] addr,
    output logic [BANK_W-1:0] bank,
    output logic              en,
    output logic [CH_W-1:0]   chIndex,
    output logic              frameStart,
    output logic              err,
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_BREAK    = 3'd1;
    localparam logic [2:0] S_SEARCH   = 3'd2;
    localparam logic [2:0] S_MAKE     = 3'd3;
    localparam logic [2:0] S_WAIT_LOW = 3'd4;

    localparam int CNT_W = ($clog2(DEAD_CYCLES + 1) > 0) ? $clog2(DEAD_CYCLES + 1) : 1;
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] LAST_DEAD = CNT_W'(DEAD_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  ptr_q, ptr_d;
    logic [CH_W-1:0]  cand_q, cand_d;
    logic [CH_W-1:0]  scan_q, scan_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic             wrap_q, wrap_d;
    logic             en_q, en_d;
    logic             fs_q, fs_d;
    logic             err_q, err_d;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
        return (c == LAST_CH) ? '0 : c + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        cand_d  = cand_q;
        scan_d  = scan_q;
        ch_d    = ch_q;
        wrap_d  = wrap_q;
        en_d    = en_q;
        fs_d    = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (switchSignal) begin
                    state_d = S_BREAK;
                    en_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_BREAK: begin
                if (cnt_q == LAST_DEAD) begin
                    state_d = S_SEARCH;
                    cand_d  = next_ch(ptr_q);
                    wrap_d  = (ptr_q == LAST_CH);
                    scan_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEARCH: begin
                // One candidate per clock; the mask is looked at live, not latched.
                if (chMask[cand_q]) begin
                    ch_d    = cand_q;
                    ptr_d   = cand_q;
                    fs_d    = wrap_q;
                    state_d = S_MAKE;
                end else if (scan_q == LAST_CH) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT_LOW;
                end else begin
                    cand_d = next_ch(cand_q);
                    wrap_d = wrap_q | (cand_q == LAST_CH);
                    scan_d = scan_q + 1'b1;
                end
            end
            S_MAKE: begin
                en_d    = 1'b1;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!switchSignal) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything, including a hit in the same clock.
        if (restart) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            ptr_d   = LAST_CH;
            ch_d    = ch_q;
            fs_d    = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= LAST_CH;
            cand_q  <= '0;
            scan_q  <= '0;
            ch_q    <= '0;
            wrap_q  <= 1'b0;
            en_q    <= 1'b0;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            cand_q  <= cand_d;
            scan_q  <= scan_d;
            ch_q    <= ch_d;
            wrap_q  <= wrap_d;
            en_q    <= en_d;
            fs_q    <= fs_d;
            err_q   <= err_d;
        end
    end

    assign addr       = ADDR_W'(ch_q);
    assign bank       = BANK_W'(ch_q >> ADDR_W);
    assign chIndex    = ch_q;
    assign en         = en_q;
    assign frameStart = fs_q;
    assign err        = err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mux_sequencer.sv
// Bench for mux_sequencer: queue-based reference of channel selection and step
// timing, with an independent monitor checking every en rise and err pulse.
module tb_mux_sequencer;
  localparam int ADDR_W = 3;
  localparam int BANK_W = 2;
  localparam int NUM_CH = 18;
  localparam int DEAD   = 2;
  localparam int CH_W   = 5;
  localparam int EW     = 23; // {is_err, frame, ch[4:0], due_cycle[15:0]}

  logic              clk = 1'b0;
  logic              reset;
  logic              switchSignal;
  logic              restart;
  logic [NUM_CH-1:0] chMask;
  logic [ADDR_W-1:0] addr;
  logic [BANK_W-1:0] bank;
  logic              en;
  logic [CH_W-1:0]   chIndex;
  logic              frameStart;
  logic              err;
  logic [2:0]        state_dbg;

  mux_sequencer #(
    .ADDR_W(ADDR_W), .BANK_W(BANK_W), .NUM_CH(NUM_CH), .DEAD_CYCLES(DEAD)
  ) dut (
    .clk(clk), .reset(reset), .switchSignal(switchSignal), .restart(restart),
    .chMask(chMask), .addr(addr), .bank(bank), .en(en), .chIndex(chIndex),
    .frameStart(frameStart), .err(err), .state_dbg(state_dbg)
  );

  // clock / cycle counter: after rising edge N, cyc reads N on the falling edge
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  int m_ptr;
  int m_ch;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: walk candidates ptr+1, ptr+2, ... and take the first enabled one
  task automatic model_step(input logic [NUM_CH-1:0] mask, input int e1, output int due);
    bit found = 0;
    bit frame = 0;
    int hit_i = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!found && mask[(m_ptr + i) % NUM_CH]) begin
        found = 1;
        hit_i = i;
        frame = (m_ptr + i >= NUM_CH);
      end
    end
    if (found) begin
      m_ptr = (m_ptr + hit_i) % NUM_CH;
      m_ch  = m_ptr;
      due   = e1 + DEAD + hit_i + 1;
      exp_q.push_back({1'b0, frame, 5'(m_ch), 16'(due)});
    end else begin
      due = e1 + DEAD + NUM_CH;
      exp_q.push_back({1'b1, 1'b0, 5'(m_ch), 16'(due)});
    end
  endtask

  // driver: raise switchSignal for 'hold' sampled edges, then wait for the step to settle
  task automatic do_step(input logic [NUM_CH-1:0] mask, input int hold);
    int e1;
    int due;
    int last;
    chMask = mask;
    switchSignal = 1'b1;
    e1 = cyc + 1;
    model_step(mask, e1, due);
    @(negedge clk);
    check("en_drop", en, 0);
    while (cyc < e1 + hold - 1) @(negedge clk);
    switchSignal = 1'b0;
    last = (due > e1 + hold - 1) ? due : e1 + hold - 1;
    while (cyc < last + 1) @(negedge clk);
  endtask

  // monitor / scoreboard
  logic [EW-1:0] mon_e;
  logic prev_en = 1'b0;
  logic prev_fs = 1'b0;
  logic [ADDR_W+BANK_W-1:0] prev_sel = '0;

  always @(negedge clk) begin
    if (reset) begin
      if ({bank, addr} != prev_sel) check("break_before_make", en, 0);
      if (en && !prev_en) begin
        if (exp_q.size() == 0 || exp_q[0][EW-1]) begin
          tests++; fails++;
          $display("FAIL unexpected_step: chIndex=%0d, expected no step", chIndex);
        end else begin
          mon_e = exp_q.pop_front();
          check("ch_index", chIndex, int'(mon_e[20:16]));
          check("addr", addr, int'(mon_e[20:16]) % (1 << ADDR_W));
          check("bank", bank, int'(mon_e[20:16]) / (1 << ADDR_W));
          check("frame_start", prev_fs, mon_e[21]);
          check("en_rise_cycle", cyc, int'(mon_e[15:0]));
        end
      end
      if (err) begin
        if (exp_q.size() == 0 || !exp_q[0][EW-1]) begin
          tests++; fails++;
          $display("FAIL unexpected_err: err=1, expected 0");
        end else begin
          mon_e = exp_q.pop_front();
          check("err_cycle", cyc, int'(mon_e[15:0]));
          check("err_en", en, 0);
          check("err_ch_hold", chIndex, int'(mon_e[20:16]));
        end
      end
      if (frameStart && exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL stray_frame_start: frameStart=1, expected 0");
      end
      if (exp_q.size() > 0 && cyc > int'(exp_q[0][15:0])) begin
        mon_e = exp_q.pop_front();
        tests++; fails++;
        $display("FAIL step_timeout: no output by cycle %0d, expected ch %0d err %0d",
                 int'(mon_e[15:0]), int'(mon_e[20:16]), mon_e[22]);
      end
    end
    prev_en  = en;
    prev_fs  = frameStart;
    prev_sel = {bank, addr};
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e1;
    logic [NUM_CH-1:0] m;
    reset = 1'b0;
    switchSignal = 1'b0;
    restart = 1'b0;
    chMask = '1;
    m_ptr = NUM_CH - 1;
    m_ch = 0;
    repeat (3) @(negedge clk);
    check("rst_addr", addr, 0);
    check("rst_bank", bank, 0);
    check("rst_ch", chIndex, 0);
    check("rst_en", en, 0);
    check("rst_fs", frameStart, 0);
    check("rst_err", err, 0);
    reset = 1'b1;
    @(negedge clk);

    // full sequence with every channel enabled: 0..17 then wrap to 0
    for (int i = 0; i < 19; i++) do_step('1, $urandom_range(1, 4));

    // sparse mask: 3, 12, 3
    for (int i = 0; i < 3; i++) do_step(18'h01008, $urandom_range(1, 3));

    // nothing enabled
    do_step('0, 2);

    // long hold produces one step only
    do_step('1, 50);
    check("hold_en_high", en, 1);
    repeat (5) @(negedge clk);
    check("hold_en_still_high", en, 1);

    // restart during BREAK
    chMask = '1;
    switchSignal = 1'b1;
    @(negedge clk);
    restart = 1'b1;
    switchSignal = 1'b0;
    @(negedge clk);
    restart = 1'b0;
    m_ptr = NUM_CH - 1;
    repeat (DEAD + NUM_CH + 3) @(negedge clk);
    check("restart_en", en, 0);
    check("restart_ch_hold", chIndex, m_ch);
    do_step('1, 1);

    // randomized masks and hold lengths
    for (int i = 0; i < 25; i++) begin
      m = NUM_CH'($urandom() & $urandom());
      if ($urandom_range(0, 7) == 0) m = '0;
      do_step(m, $urandom_range(1, 3));
    end

    // reset asserted while searching
    do_step(18'h00020, 1);
    chMask = '1;
    switchSignal = 1'b1;
    e1 = cyc + 1;
    while (cyc < e1 + DEAD) @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rst_addr", addr, 0);
    check("async_rst_bank", bank, 0);
    check("async_rst_ch", chIndex, 0);
    check("async_rst_en", en, 0);
    check("async_rst_fs", frameStart, 0);
    check("async_rst_err", err, 0);
    switchSignal = 1'b0;
    m_ptr = NUM_CH - 1;
    m_ch = 0;
    repeat (2) @(negedge clk);
    check("rst_no_update", chIndex, 0);
    reset = 1'b1;
    @(negedge clk);
    do_step(18'h000F0, 1);
    do_step(18'h000F0, 2);

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
